cnt_seq_checker: RTL

Loopback sequence checker for the test chip. Samples an 8-bit bus carrying the free-running counter driven by the counter stage (tied back externally from uio to ui), locks onto the +1-per-sample sequence and counts deviations. Status and error count go out on dedicated outputs so a tester can confirm the counter stage, pad ring and clocking in one pass.

---
 rtl/cnt_seq_checker.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/cnt_seq_checker.sv
// ---------------------------------------------------------------------------
// cnt_seq_checker
//
// Loopback sequence checker for the test chip. It watches an 8-bit bus that
// carries the free-running counter from the counter stage, locks onto the
// "+1 per sample" sequence and counts every deviation seen while locked.
// A tester can read lock status, a per-error pulse, a saturating error count
// and a sticky error flag. An optional pair of registers captures the
// expected and received values of the first counted mismatch.
//
// Optional feature macro:
//   SEQ_CHK_CAPTURE_EN  - when defined, the first-mismatch capture registers
//                         are built. When undefined, cap_valid/cap_exp/cap_got
//                         are tied to 0 and everything else behaves the same.
//
// Parameters:
//   LOCK_CNT  consecutive correct increments needed to lock (>=1)
//   LOSS_CNT  consecutive mismatches while locked that drop lock (>=1)
//   ERR_W     width of the saturating error counter (>=1)
//
// Ports:
//   clk         in   1      clock
//   rst_n       in   1      asynchronous, active-low reset
//   en          in   1      sample enable; din is consumed only when en=1
//   din         in   8      observed counter value
//   clr         in   1      synchronous clear of err_cnt, err_sticky, capture
//   locked      out  1      high while in the locked state
//   err_pulse   out  1      one-cycle pulse per counted mismatch
//   err_cnt     out  ERR_W  saturating count of counted mismatches
//   err_sticky  out  1      set on first counted mismatch, held until clr
//   cap_valid   out  1      capture registers hold a mismatch
//   cap_exp     out  8      expected value at first captured mismatch
//   cap_got     out  8      received value at first captured mismatch
// ---------------------------------------------------------------------------
module cnt_seq_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [7:0]       din,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_sticky,
  output logic             cap_valid,
  output logic [7:0]       cap_exp,
  output logic [7:0]       cap_got
);

  // Run counters only need to reach their thresholds, so size them to fit
  // exactly LOCK_CNT / LOSS_CNT.
  localparam int GW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam int BW = (LOSS_CNT < 1) ? 1 : $clog2(LOSS_CNT + 1);
  localparam logic [GW-1:0] LOCK_TGT = GW'(LOCK_CNT);
  localparam logic [BW-1:0] LOSS_TGT = BW'(LOSS_CNT);

  typedef enum logic [1:0] {
    ST_UNLOCK = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCK   = 2'd2
  } state_t;

  state_t           r_state;
  logic [7:0]       r_ref;
  logic [GW-1:0]    r_goodRun;
  logic [BW-1:0]    r_badRun;
  logic             r_locked;
  logic             r_errPulse;
  logic [ERR_W-1:0] r_errCnt;
  logic             r_errSticky;

  logic [7:0]       w_expected;
  logic             w_match;
  logic [GW-1:0]    w_goodNext;
  logic [BW-1:0]    w_badNext;
  logic             w_countErr;

  // The expected sample is always the reference plus one; 8-bit arithmetic
  // makes 0xFF -> 0x00 a match for free. A mismatch is only "counted" when
  // it is sampled while locked.
  always_comb begin
    w_expected = r_ref + 8'd1;
    w_match    = (din == w_expected);
    w_goodNext = r_goodRun + GW'(1);
    w_badNext  = r_badRun + BW'(1);
    w_countErr = en && (r_state == ST_LOCK) && !w_match;
  end

  // Main lock FSM together with the reference register and the good/bad
  // run counters. UNLOCK seeds the reference from the first sample, ACQ
  // counts consecutive increments until LOCK_CNT is reached, and LOCK keeps
  // the expected value advancing even through mismatches (flywheel) so a
  // single corrupted sample costs exactly one error. LOSS_CNT consecutive
  // mismatches fall back to ACQ, reseeding from the current sample. clr has
  // no influence here at all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_UNLOCK;
      r_ref      <= 8'd0;
      r_goodRun  <= '0;
      r_badRun   <= '0;
      r_locked   <= 1'b0;
      r_errPulse <= 1'b0;
    end else begin
      r_errPulse <= 1'b0;
      if (en) begin
        unique case (r_state)
          ST_UNLOCK: begin
            r_ref     <= din;
            r_goodRun <= '0;
            r_state   <= ST_ACQ;
          end
          ST_ACQ: begin
            r_ref <= din;
            if (w_match) begin
              r_goodRun <= w_goodNext;
              if (w_goodNext == LOCK_TGT) begin
                r_state  <= ST_LOCK;
                r_locked <= 1'b1;
                r_badRun <= '0;
              end
            end else begin
              r_goodRun <= '0;
            end
          end
          ST_LOCK: begin
            if (w_match) begin
              r_badRun <= '0;
              r_ref    <= din;
            end else begin
              r_errPulse <= 1'b1;
              if (w_badNext == LOSS_TGT) begin
                r_state   <= ST_ACQ;
                r_locked  <= 1'b0;
                r_ref     <= din;
                r_goodRun <= '0;
                r_badRun  <= '0;
              end else begin
                r_badRun <= w_badNext;
                r_ref    <= w_expected;
              end
            end
          end
          default: begin
            r_state  <= ST_UNLOCK;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // Error bookkeeping. clr takes priority over a coincident counted mismatch
  // so the tester always sees a clean zero after clearing; the pulse from
  // that same mismatch still comes out of the FSM block above. The counter
  // holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_errCnt    <= '0;
      r_errSticky <= 1'b0;
    end else if (clr) begin
      r_errCnt    <= '0;
      r_errSticky <= 1'b0;
    end else if (w_countErr) begin
      r_errSticky <= 1'b1;
      if (r_errCnt != {ERR_W{1'b1}}) begin
        r_errCnt <= r_errCnt + ERR_W'(1);
      end
    end
  end

`ifdef SEQ_CHK_CAPTURE_EN
  logic       r_capValid;
  logic [7:0] r_capExp;
  logic [7:0] r_capGot;

  // First-mismatch capture: only the first counted mismatch after reset or
  // clr is recorded, later ones leave the registers alone so the tester sees
  // the original failure rather than its aftermath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_capValid <= 1'b0;
      r_capExp   <= 8'd0;
      r_capGot   <= 8'd0;
    end else if (clr) begin
      r_capValid <= 1'b0;
      r_capExp   <= 8'd0;
      r_capGot   <= 8'd0;
    end else if (w_countErr && !r_capValid) begin
      r_capValid <= 1'b1;
      r_capExp   <= w_expected;
      r_capGot   <= din;
    end
  end

  assign cap_valid = r_capValid;
  assign cap_exp   = r_capExp;
  assign cap_got   = r_capGot;
`else
  assign cap_valid = 1'b0;
  assign cap_exp   = 8'd0;
  assign cap_got   = 8'd0;
`endif

  assign locked     = r_locked;
  assign err_pulse  = r_errPulse;
  assign err_cnt    = r_errCnt;
  assign err_sticky = r_errSticky;

endmodule
